// File: rtl/alu_pkg.sv
// Shared definitions for the ALU unit interface: unit select codes, sequencer
// state encoding and shift function codes.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } seq_state_e;

  typedef enum logic [1:0] {
    SHR_A = 2'b00,
    SHL_A = 2'b01,
    SHR_B = 2'b10,
    SHL_B = 2'b11
  } shift_func_e;

  // Bit i of the result is set for unit code i.
  function automatic logic [3:0] unit_onehot(input unit_sel_e sel);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_unit_select.sv
// Decodes the latched unit select into one-hot enables and steers the
// selected unit's flag/result back to the sequencer.
module alu_unit_select
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  unit_sel_e        sel,
  input  logic             issue,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             arith_en,
  output logic             logic_en,
  output logic             cmp_en,
  output logic             shift_en,
  output logic             sel_flag,
  output logic [WIDTH-1:0] sel_out
);

  logic [3:0] onehot;

  always_comb begin
    onehot   = unit_onehot(sel);
    arith_en = issue & onehot[UNIT_ARITH];
    logic_en = issue & onehot[UNIT_LOGIC];
    cmp_en   = issue & onehot[UNIT_CMP];
    shift_en = issue & onehot[UNIT_SHIFT];
  end

  // Only the selected unit is observed; stray flags from the others never leak through.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (sel)
      UNIT_ARITH: begin sel_flag = arith_flag; sel_out = arith_out; end
      UNIT_LOGIC: begin sel_flag = logic_flag; sel_out = logic_out; end
      UNIT_CMP:   begin sel_flag = cmp_flag;   sel_out = cmp_out;   end
      UNIT_SHIFT: begin sel_flag = shift_flag; sel_out = shift_out; end
      default:    begin sel_flag = 1'b0;       sel_out = '0;        end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU unit interface: takes one command at a time, pulses
// one unit enable, waits (with timeout) for the unit flag and returns the result.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_FUNC,
  output logic             ARITH_Enable,
  output logic             LOGIC_Enable,
  output logic             CMP_Enable,
  output logic             SHIFT_Enable,
  input  logic [WIDTH-1:0] ARITH_OUT,
  input  logic [WIDTH-1:0] LOGIC_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             ARITH_Flag,
  input  logic             LOGIC_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  unit_sel_e        sel_q, sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             sel_flag;
  logic [WIDTH-1:0] sel_out;

  alu_unit_select #(.WIDTH(WIDTH)) u_unit_select (
    .sel        (sel_q),
    .issue      (state_q == ST_ISSUE),
    .arith_out  (ARITH_OUT),
    .logic_out  (LOGIC_OUT),
    .cmp_out    (CMP_OUT),
    .shift_out  (SHIFT_OUT),
    .arith_flag (ARITH_Flag),
    .logic_flag (LOGIC_Flag),
    .cmp_flag   (CMP_Flag),
    .shift_flag (SHIFT_Flag),
    .arith_en   (ARITH_Enable),
    .logic_en   (LOGIC_Enable),
    .cmp_en     (CMP_Enable),
    .shift_en   (SHIFT_Enable),
    .sel_flag   (sel_flag),
    .sel_out    (sel_out)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      sel_q       <= UNIT_ARITH;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      func_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      func_q      <= func_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    func_d      = func_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          func_d  = cmd_op[1:0];
          sel_d   = unit_sel_e'(cmd_op[3:2]);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      // The counter stops at CNT_LAST, so it can never wrap.
      ST_WAIT: begin
        if (sel_flag) begin
          rsp_data_d  = sel_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUNC  = func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with simple registered unit stubs.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'h0;
  logic [15:0] cmd_a = 16'h0;
  logic [15:0] cmd_b = 16'h0;
  logic [15:0] ALU_A, ALU_B;
  logic [1:0]  ALU_FUNC;
  logic        ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic        ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Unit stubs: alive bits {arith, logic, cmp, shift}; spurious drives a stray arith flag.
  logic [3:0]  alive = 4'b1111;
  logic        spurious = 1'b0;
  logic        arith_f = 1'b0, logic_f = 1'b0, cmp_f = 1'b0, shift_f = 1'b0;
  logic [15:0] arith_r = '0, logic_r = '0, cmp_r = '0, shift_r = '0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    arith_f <= ARITH_Enable & alive[3];
    logic_f <= LOGIC_Enable & alive[2];
    cmp_f   <= CMP_Enable   & alive[1];
    shift_f <= SHIFT_Enable & alive[0];
    if (ARITH_Enable)
      case (ALU_FUNC)
        2'b00: arith_r <= ALU_A + ALU_B;
        2'b01: arith_r <= ALU_A - ALU_B;
        2'b10: arith_r <= ALU_A + 16'd1;
        default: arith_r <= ALU_A - 16'd1;
      endcase
    if (LOGIC_Enable)
      case (ALU_FUNC)
        2'b00: logic_r <= ALU_A & ALU_B;
        2'b01: logic_r <= ALU_A | ALU_B;
        2'b10: logic_r <= ALU_A ^ ALU_B;
        default: logic_r <= ~ALU_A;
      endcase
    if (CMP_Enable)
      case (ALU_FUNC)
        2'b00: cmp_r <= {15'd0, ALU_A == ALU_B};
        2'b01: cmp_r <= {15'd0, ALU_A > ALU_B};
        2'b10: cmp_r <= {15'd0, ALU_A < ALU_B};
        default: cmp_r <= 16'd0;
      endcase
    if (SHIFT_Enable)
      case (ALU_FUNC)
        2'b00: shift_r <= ALU_A >> 1;
        2'b01: shift_r <= ALU_A << 1;
        2'b10: shift_r <= ALU_B >> 1;
        default: shift_r <= ALU_B << 1;
      endcase
  end

  assign ARITH_OUT = arith_r;
  assign LOGIC_OUT = logic_r;
  assign CMP_OUT   = cmp_r;
  assign SHIFT_OUT = shift_r;
  assign ARITH_Flag = arith_f | spurious;
  assign LOGIC_Flag = logic_f;
  assign CMP_Flag   = cmp_f;
  assign SHIFT_Flag = shift_f;

  alu_cmd_sequencer #(.WIDTH(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .ARITH_Enable(ARITH_Enable), .LOGIC_Enable(LOGIC_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .ARITH_Flag(ARITH_Flag), .LOGIC_Flag(LOGIC_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a command and returns #1 after the handshake edge (cycle N+1).
  task automatic send_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int waited;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    tests_run++;
    if (!cmd_ready) begin
      tests_failed++;
      $display("[TB] FAIL send_cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    rsp_ready = 1'b0;
    #2;
    tests_run++;
    if ({cmd_ready, rsp_valid, rsp_err, ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable} !== 7'b1000000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b required 1000000",
               {cmd_ready, rsp_valid, rsp_err, ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable});
    end
    tests_run++;
    if ({ALU_A, ALU_B, ALU_FUNC, rsp_data} !== 50'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: A=%h B=%h F=%b D=%h required all 0", ALU_A, ALU_B, ALU_FUNC, rsp_data);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    step();
  endtask

  task automatic test_shift_latency();
    rsp_ready = 1'b1;
    send_cmd(4'b1100, 16'h0010, 16'hABCD);
    tests_run++;
    if ({ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, cmd_ready} !== 5'b00010) begin
      tests_failed++;
      $display("[TB] FAIL issue_enables: got %b required 00010",
               {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, cmd_ready});
    end
    tests_run++;
    if ({ALU_A, ALU_B, ALU_FUNC} !== {16'h0010, 16'hABCD, 2'b00}) begin
      tests_failed++;
      $display("[TB] FAIL issue_operands: A=%h B=%h F=%b required 0010 abcd 00", ALU_A, ALU_B, ALU_FUNC);
    end
    step();
    tests_run++;
    if ({ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, rsp_valid} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL wait_enables: got %b required 00000",
               {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable, rsp_valid});
    end
    step();
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0008}) begin
      tests_failed++;
      $display("[TB] FAIL shift_rsp: valid=%b err=%b data=%h required 1 0 0008", rsp_valid, rsp_err, rsp_data);
    end
    step();
    tests_run++;
    if ({rsp_valid, cmd_ready, ALU_A} !== {1'b0, 1'b1, 16'h0010}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_idle: valid=%b ready=%b A=%h required 0 1 0010", rsp_valid, cmd_ready, ALU_A);
    end
  endtask

  task automatic test_functions();
    logic [3:0]  ops [5] = '{4'b1111, 4'b1101, 4'b0001, 4'b0111, 4'b1001};
    logic [15:0] as  [5] = '{16'h1234, 16'hFFFF, 16'h0100, 16'h5A5A, 16'h0003};
    logic [15:0] bs  [5] = '{16'h8001, 16'h0000, 16'h0001, 16'h0000, 16'h0002};
    logic [15:0] exp [5] = '{16'h0002, 16'hFFFE, 16'h00FF, 16'hA5A5, 16'h0001};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_cmd(ops[i], as[i], bs[i]);
      step();
      step();
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, exp[i]}) begin
        tests_failed++;
        $display("[TB] FAIL func_%0d op=%b: valid=%b err=%b data=%h required 1 0 %h",
                 i, ops[i], rsp_valid, rsp_err, rsp_data, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic held_ok;
    rsp_ready = 1'b0;
    send_cmd(4'b0000, 16'h0011, 16'h0022);
    step();
    step();
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, 1'b0, 16'h0033, 1'b0}) held_ok = 1'b0;
      step();
    end
    tests_run++;
    if (held_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_hold: stable=%b required 1 (last valid=%b data=%h ready=%b)",
               held_ok, rsp_valid, rsp_data, cmd_ready);
    end
    rsp_ready = 1'b1;
    step();
    tests_run++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_release: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    logic early;
    rsp_ready = 1'b1;
    alive = 4'b1110;
    spurious = 1'b1;
    send_cmd(4'b1100, 16'h0010, 16'h0000);
    early = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      if (rsp_valid !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_early_rsp: early=%b required 0", early);
    end
    step();
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_rsp: valid=%b err=%b data=%h required 1 1 0000", rsp_valid, rsp_err, rsp_data);
    end
    spurious = 1'b0;
    alive = 4'b1111;
    step();
  endtask

  task automatic test_reset_mid_op();
    logic leaked;
    rsp_ready = 1'b1;
    alive = 4'b0000;
    send_cmd(4'b0100, 16'hBEEF, 16'h1111);
    step();
    RST = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, rsp_valid, rsp_err, ALU_A, ALU_B, ALU_FUNC} !== {1'b1, 1'b0, 1'b0, 34'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_op: ready=%b valid=%b A=%h B=%h F=%b required 1 0 0 0 0",
               cmd_ready, rsp_valid, ALU_A, ALU_B, ALU_FUNC);
    end
    alive = 4'b1111;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid !== 1'b0) leaked = 1'b1;
    end
    tests_run++;
    if (leaked !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_rsp: leaked=%b required 0", leaked);
    end
    send_cmd(4'b1110, 16'h0000, 16'h0100);
    step();
    step();
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0080}) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_op: valid=%b err=%b data=%h required 1 0 0080", rsp_valid, rsp_err, rsp_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 4'b0000;
    cmd_a = 16'h1234;
    cmd_b = 16'h0101;
    step();
    cmd_op = 4'b0110;
    cmd_a = 16'h00FF;
    cmd_b = 16'h0F0F;
    tests_run++;
    if ({ARITH_Enable, LOGIC_Enable, ALU_A} !== {1'b1, 1'b0, 16'h1234}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first_issue: arith=%b logic=%b A=%h required 1 0 1234", ARITH_Enable, LOGIC_Enable, ALU_A);
    end
    step();
    tests_run++;
    if ({cmd_ready, ALU_A} !== {1'b0, 16'h1234}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_not_taken: ready=%b A=%h required 0 1234", cmd_ready, ALU_A);
    end
    step();
    tests_run++;
    if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 16'h1335, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first_rsp: valid=%b data=%h ready=%b required 1 1335 0", rsp_valid, rsp_data, cmd_ready);
    end
    step();
    tests_run++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: ready=%b valid=%b required 1 0", cmd_ready, rsp_valid);
    end
    step();
    cmd_valid = 1'b0;
    tests_run++;
    if ({ARITH_Enable, LOGIC_Enable, ALU_A, ALU_FUNC} !== {1'b0, 1'b1, 16'h00FF, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_issue: arith=%b logic=%b A=%h F=%b required 0 1 00ff 10",
               ARITH_Enable, LOGIC_Enable, ALU_A, ALU_FUNC);
    end
    step();
    step();
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 16'h0FF0}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_rsp: valid=%b err=%b data=%h required 1 0 0ff0", rsp_valid, rsp_err, rsp_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_shift_latency();
    test_functions();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
